// File: rtl/gate_truth_checker.sv
// gate_truth_checker: response monitor for two-input gate exercises.
// It watches the a/b stimulus and the gate output y. After each announced
// vector it waits SETTLE cycles, then samples y. It builds the observed
// 4-entry truth table (bit index = {a,b}). Once all four vectors have been
// seen, it compares the table against EXPECTED_TT.
// SETTLE must lie in 1..15, because the settle counter is 4 bits wide.
module gate_truth_checker #(
  parameter logic [3:0]  EXPECTED_TT = 4'b1000,
  parameter int unsigned SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed_tt,
  output logic [3:0] mismatch_mask,
  output logic       inconsistent,
  output logic       settle_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VEC,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t     state, next_state;
  logic [1:0] vec;
  logic [1:0] ab;
  logic [3:0] cnt;
  logic [3:0] seen;
  logic [3:0] seen_next;
  logic       abort;
  logic       sample_now;

  assign ab         = {a, b};
  // A vector is discarded if its inputs move before y has been sampled.
  assign abort      = (state == S_SETTLE) && (ab != vec);
  assign sample_now = (state == S_SETTLE) && !abort && (cnt == 4'd1);
  assign seen_next  = seen | (4'b0001 << vec);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    next_state = state;
    unique case (state)
      S_IDLE:     if (start) next_state = S_WAIT_VEC;
      S_WAIT_VEC: if (in_valid) next_state = S_SETTLE;
      S_SETTLE: begin
        if (abort)           next_state = S_WAIT_VEC;
        else if (sample_now) next_state = (seen_next == 4'b1111) ? S_COMPARE : S_WAIT_VEC;
      end
      S_COMPARE:  next_state = S_DONE;
      S_DONE:     if (start) next_state = S_WAIT_VEC;
      default:    next_state = S_IDLE;
    endcase
  end

  // Status flags registered from the next state, so they change on the same
  // edge as the state itself and have no combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (next_state == S_WAIT_VEC);
      busy  <= (next_state == S_WAIT_VEC) || (next_state == S_SETTLE) ||
               (next_state == S_COMPARE);
      done  <= (next_state == S_DONE);
    end
  end

  // Vector capture, settle countdown, table update and final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the table and seen bits are only four flops each and carry run
    // state, so they sit on the async reset like every other register.
    if (!rst_n) begin
      vec           <= 2'b00;
      cnt           <= 4'd0;
      seen          <= 4'b0000;
      observed_tt   <= 4'b0000;
      mismatch_mask <= 4'b0000;
      inconsistent  <= 1'b0;
      settle_err    <= 1'b0;
      pass          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seen          <= 4'b0000;
            observed_tt   <= 4'b0000;
            mismatch_mask <= 4'b0000;
            inconsistent  <= 1'b0;
            settle_err    <= 1'b0;
            pass          <= 1'b0;
          end
        end
        S_WAIT_VEC: begin
          if (in_valid) begin
            vec <= ab;
            cnt <= 4'(SETTLE);
          end
        end
        S_SETTLE: begin
          if (abort) begin
            settle_err <= 1'b1;
          end else if (sample_now) begin
            if (seen[vec] && (observed_tt[vec] != y)) inconsistent <= 1'b1;
            observed_tt[vec] <= y;
            seen[vec]        <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_COMPARE: begin
          mismatch_mask <= observed_tt ^ EXPECTED_TT;
          pass          <= (observed_tt == EXPECTED_TT) && !inconsistent && !settle_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. It runs two instances: AND with SETTLE=2,
// and XOR with SETTLE=1. Expected results come from a truth-table model
// kept as plain arrays.
module tb_gate_truth_checker;

  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [3:0] EXP_XOR = 4'b0110;

  logic clk = 1'b0;
  logic rst_n, start0, start1, in_valid, a, b, y;

  logic       ready0, busy0, done0, pass0, inc0, serr0;
  logic [3:0] obs0, mask0;
  logic       ready1, busy1, done1, pass1, inc1, serr1;
  logic [3:0] obs1, mask1;

  gate_truth_checker #(.EXPECTED_TT(EXP_AND), .SETTLE(2)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid),
    .a(a), .b(b), .y(y), .ready(ready0), .busy(busy0), .done(done0),
    .pass(pass0), .observed_tt(obs0), .mismatch_mask(mask0),
    .inconsistent(inc0), .settle_err(serr0));

  gate_truth_checker #(.EXPECTED_TT(EXP_XOR), .SETTLE(1)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid),
    .a(a), .b(b), .y(y), .ready(ready1), .busy(busy1), .done(done1),
    .pass(pass1), .observed_tt(obs1), .mismatch_mask(mask1),
    .inconsistent(inc1), .settle_err(serr1));

  always #5 clk = ~clk;

  // Selects which instance is observed: 0 = AND, 1 = XOR.
  int sel = 0;
  logic       c_ready, c_busy, c_done, c_pass, c_inc, c_serr;
  logic [3:0] c_obs, c_mask;
  assign c_ready = (sel != 0) ? ready1 : ready0;
  assign c_busy  = (sel != 0) ? busy1  : busy0;
  assign c_done  = (sel != 0) ? done1  : done0;
  assign c_pass  = (sel != 0) ? pass1  : pass0;
  assign c_inc   = (sel != 0) ? inc1   : inc0;
  assign c_serr  = (sel != 0) ? serr1  : serr0;
  assign c_obs   = (sel != 0) ? obs1   : obs0;
  assign c_mask  = (sel != 0) ? mask1  : mask0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the truth table as seen so far.
  bit m_seen[4];
  bit m_obs[4];
  bit m_inc, m_serr, m_running, m_done;
  time accept_t[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit m_all_seen();
    return m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
  endfunction

  function automatic logic [3:0] m_table();
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = m_obs[i];
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 1'b0;
      m_obs[i]  = 1'b0;
    end
    m_inc  = 1'b0;
    m_serr = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_tt, tbl;
    bit         exp_pass;
    exp_tt   = (sel != 0) ? EXP_XOR : EXP_AND;
    tbl      = m_table();
    exp_pass = m_done && (tbl == exp_tt) && !m_inc && !m_serr;
    check({tag, ".observed_tt"},   c_obs,  tbl);
    check({tag, ".mismatch_mask"}, c_mask, m_done ? (tbl ^ exp_tt) : 4'b0000);
    check({tag, ".pass"},          c_pass, exp_pass);
    check({tag, ".done"},          c_done, m_done);
    check({tag, ".busy"},          c_busy, m_running && !m_done);
    check({tag, ".ready"},         c_ready, m_running && !m_done && !m_all_seen());
    check({tag, ".inconsistent"},  c_inc,  m_inc);
    check({tag, ".settle_err"},    c_serr, m_serr);
  endtask

  task automatic do_start();
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    model_clear();
    m_running = 1'b1;
    check_all("start");
  endtask

  // Applies one vector. When violate is set, b moves during settle.
  // When poke_start is set, start is pulsed in the first settle cycle.
  task automatic send(input logic [1:0] v, input logic yv, input bit violate, input bit poke_start);
    int n;
    int st;
    st = (sel != 0) ? 1 : 2;
    n  = 0;
    while (!c_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!c_ready) check("ready_wait", c_ready, 1);
    {a, b}   = v;
    y        = yv;
    in_valid = 1'b1;
    accept_t.push_back($time);
    @(negedge clk);
    in_valid = 1'b0;
    check("ready_in_settle", c_ready, 0);
    check("busy_in_settle", c_busy, 1);
    if (violate) begin
      b = ~b;
      @(negedge clk);
      m_serr = 1'b1;
      check_all("settle_abort");
      return;
    end
    if (poke_start) begin
      if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    end
    repeat (st) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
    end
    if (m_seen[v] && (m_obs[v] != yv)) m_inc = 1'b1;
    m_obs[v]  = yv;
    m_seen[v] = 1'b1;
    if (m_all_seen()) begin
      check("compare.done", c_done, 0);
      check("compare.busy", c_busy, 1);
      @(negedge clk);
      m_done    = 1'b1;
      m_running = 1'b0;
      check_all("done");
    end else begin
      check_all("after_sample");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    logic       yv;
    logic [3:0] tt;
    int         k;

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; y = 1'b0;
    model_clear();
    m_running = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Correct AND gate, with a start pulse inside settle that must be ignored.
    sel = 0;
    do_start();
    send(2'd0, 1'b0, 0, 0);
    send(2'd1, 1'b0, 0, 1);
    send(2'd2, 1'b0, 0, 0);
    send(2'd3, 1'b1, 0, 0);

    // Faulty DUT: stuck-at-0 on vector 11.
    do_start();
    send(2'd0, 1'b0, 0, 0);
    send(2'd1, 1'b0, 0, 0);
    send(2'd2, 1'b0, 0, 0);
    send(2'd3, 1'b0, 0, 0);

    // Duplicate and out-of-order vectors, with a changing answer on 11.
    do_start();
    send(2'd3, 1'b1, 0, 0);
    send(2'd0, 1'b0, 0, 0);
    send(2'd3, 1'b0, 0, 0);
    send(2'd1, 1'b0, 0, 0);
    send(2'd2, 1'b0, 0, 0);

    // Settle violation on 01, then clean reapplication.
    do_start();
    send(2'd1, 1'b0, 1, 0);
    send(2'd0, 1'b0, 0, 0);
    send(2'd2, 1'b0, 0, 0);
    send(2'd3, 1'b1, 0, 0);
    send(2'd1, 1'b0, 0, 0);

    // Reset after three vectors aborts the run.
    do_start();
    send(2'd0, 1'b0, 0, 0);
    send(2'd1, 1'b0, 0, 0);
    send(2'd2, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    m_running = 1'b0;
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    send(2'd0, 1'b0, 0, 0);
    send(2'd1, 1'b0, 0, 0);
    send(2'd2, 1'b0, 0, 0);
    send(2'd3, 1'b1, 0, 0);

    // Randomised runs on the AND instance.
    tt = EXP_AND;
    for (int run = 0; run < 6; run++) begin
      do_start();
      k = 0;
      while (!m_all_seen() && k < 40) begin
        v = 2'($urandom_range(0, 3));
        if (k > 8) begin
          for (int i = 3; i >= 0; i--) if (!m_seen[i]) v = 2'(i);
        end
        yv = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : tt[v];
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(v, yv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        k++;
      end
      check("random_run_complete", c_done, 1);
    end

    // XOR instance with SETTLE=1: vectors back-to-back every two cycles.
    sel = 1;
    do_start();
    accept_t.delete();
    send(2'd2, 1'b1, 0, 0);
    send(2'd0, 1'b0, 0, 0);
    send(2'd3, 1'b0, 0, 0);
    send(2'd1, 1'b1, 0, 0);
    for (int i = 1; i < 4; i++)
      check("xor_throughput", 32'(accept_t[i] - accept_t[i-1]), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
